// File: rtl/pc_branch_unit.sv
// PC register and branch/jump resolution for the single-cycle CPU; misaligned targets trap until acknowledged.
// Optional feature: define PC_BRANCH_STATS_EN to add br_count / br_taken_count outputs.
module pc_branch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        stall,
    input  logic        branch,
    input  logic        jal,
    input  logic        jalr,
    input  logic [2:0]  br_func,
    input  logic        alu_zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] imm,
    input  logic        trap_clear,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        taken,
    output logic        trap,
    output logic [31:0] trap_addr
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] br_taken_count
`endif
);

    typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic        trap_next;
    logic [31:0] trap_addr_next;

    logic        cond;
    logic        br_take;
    logic [31:0] pc_imm;
    logic [31:0] target;
    logic        retire;
    logic        misaligned;

    // The ALU runs SUB for BEQ/BNE and SLT/SLTU for the rest, so zero means "less-than is false" there.
    always_comb begin
        cond = 1'b0;
        case (br_func)
            3'b000:         cond = alu_zero;
            3'b001:         cond = ~alu_zero;
            3'b100, 3'b110: cond = ~alu_zero;
            3'b101, 3'b111: cond = alu_zero;
            default:        cond = 1'b0;
        endcase
    end

    assign br_take    = branch & cond;
    assign taken      = jalr | jal | br_take;
    assign pc_plus4   = pc + 32'd4;
    assign pc_imm     = pc + imm;
    assign target     = jalr ? {alu_result[31:1], 1'b0}
                      : (jal | br_take) ? pc_imm
                      : pc_plus4;
    assign retire     = step & ~stall;
    assign misaligned = (target[1:0] != 2'b00);

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        trap_next      = trap;
        trap_addr_next = trap_addr;
        case (state)
            RUN: begin
                if (retire) begin
                    if (misaligned) begin
                        trap_addr_next = target;
                        trap_next      = 1'b1;
                        state_next     = TRAP;
                    end else begin
                        pc_next = target;
                    end
                end
            end
            TRAP: begin
                // trap_clear wins over stall; everything else is fenced off here.
                if (trap_clear) begin
                    pc_next    = TRAP_VECTOR;
                    trap_next  = 1'b0;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_VECTOR;
            trap      <= 1'b0;
            trap_addr <= 32'h0000_0000;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            trap      <= trap_next;
            trap_addr <= trap_addr_next;
        end
    end

`ifdef PC_BRANCH_STATS_EN
    logic count_en;

    // Only true conditional branches that actually retire without trapping are counted.
    assign count_en = (state == RUN) & retire & branch & ~jal & ~jalr & ~misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count       <= 32'd0;
            br_taken_count <= 32'd0;
        end else if (count_en) begin
            br_count <= br_count + 32'd1;
            if (cond) begin
                br_taken_count <= br_taken_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed and randomized checks of pc_branch_unit against a behavioural PC/trap model.
// Define PC_BRANCH_STATS_EN to also check the branch statistics counters.
module tb_pc_branch_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        step;
    logic        stall;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  br_func;
    logic        alu_zero;
    logic [31:0] alu_result;
    logic [31:0] imm;
    logic        trap_clear;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        trap;
    logic [31:0] trap_addr;
`ifdef PC_BRANCH_STATS_EN
    logic [31:0] br_count;
    logic [31:0] br_taken_count;
`endif

    pc_branch_unit #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst(rst), .step(step), .stall(stall), .branch(branch),
        .jal(jal), .jalr(jalr), .br_func(br_func), .alu_zero(alu_zero),
        .alu_result(alu_result), .imm(imm), .trap_clear(trap_clear),
        .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .trap(trap),
        .trap_addr(trap_addr)
`ifdef PC_BRANCH_STATS_EN
        , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic        m_trap;
    logic [31:0] m_addr;
    logic        m_known;
    logic [31:0] m_bc;
    logic [31:0] m_btc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_cond(input logic [2:0] f, input logic z);
        logic equal;
        logic less;
        equal = z;
        less  = !z;
        case (f)
            3'd0: return equal;
            3'd1: return !equal;
            3'd4, 3'd6: return less;
            3'd5, 3'd7: return !less;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive inputs, check combinational outputs, advance model, check registered outputs.
    task automatic cyc(input logic r, input logic s, input logic st, input logic b,
                       input logic j, input logic jr, input logic [2:0] f, input logic z,
                       input logic [31:0] alu, input logic [31:0] im, input logic clr);
        logic        c;
        logic        e_taken;
        logic [31:0] tgt;
        rst = r; step = s; stall = st; branch = b; jal = j; jalr = jr;
        br_func = f; alu_zero = z; alu_result = alu; imm = im; trap_clear = clr;
        c       = b && m_cond(f, z);
        e_taken = jr || j || c;
        if (jr)
            tgt = alu & 32'hFFFF_FFFE;
        else if (j || c)
            tgt = m_pc + im;
        else
            tgt = m_pc + 32'd4;
        #3;
        chk("taken", {31'd0, taken}, {31'd0, e_taken});
        if (m_known) chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        @(posedge clk);
        if (r) begin
            m_pc = RV; m_trap = 1'b0; m_addr = 32'd0; m_known = 1'b1;
            m_bc = 32'd0; m_btc = 32'd0;
        end else if (m_trap) begin
            if (clr) begin
                m_pc = TV; m_trap = 1'b0;
            end
        end else if (s && !st) begin
            if (tgt % 4 != 0) begin
                m_addr = tgt; m_trap = 1'b1;
            end else begin
                if (b && !j && !jr) begin
                    m_bc = m_bc + 32'd1;
                    if (c) m_btc = m_btc + 32'd1;
                end
                m_pc = tgt;
            end
        end
        #1;
        chk("pc", pc, m_pc);
        chk("trap", {31'd0, trap}, {31'd0, m_trap});
        chk("trap_addr", trap_addr, m_addr);
`ifdef PC_BRANCH_STATS_EN
        chk("br_count", br_count, m_bc);
        chk("br_taken_count", br_taken_count, m_btc);
`endif
    endtask

    task automatic go_to(input logic [31:0] a);
        cyc(0, 1, 0, 0, 0, 1, 3'd0, 0, a, 32'd0, 0);
    endtask

    initial begin
        m_pc = 32'd0; m_trap = 1'b0; m_addr = 32'd0; m_known = 1'b0;
        m_bc = 32'd0; m_btc = 32'd0;
        rst = 1; step = 0; stall = 0; branch = 0; jal = 0; jalr = 0;
        br_func = 0; alu_zero = 0; alu_result = 0; imm = 0; trap_clear = 0;
        @(posedge clk); #1;

        // Reset and sequential stepping
        cyc(1, 0, 0, 0, 0, 0, 3'd0, 0, 32'd0, 32'd0, 0);
        chk("reset_pc", pc, 32'h0);
        chk("reset_trap", {31'd0, trap}, 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 3'd0, 0, 32'd0, 32'd0, 0);
        chk("seq_pc", pc, 32'd12);

        // BEQ taken / not taken
        go_to(32'h40);
        cyc(0, 1, 0, 1, 0, 0, 3'd0, 1, 32'd0, -32'sd16, 0);
        chk("beq_taken_pc", pc, 32'h30);
        go_to(32'h40);
        cyc(0, 1, 0, 1, 0, 0, 3'd0, 0, 32'd0, -32'sd16, 0);
        chk("beq_not_pc", pc, 32'h44);

        // BLT stalled for two cycles
        go_to(32'h30);
        cyc(0, 1, 1, 1, 0, 0, 3'd4, 0, 32'd0, 32'd8, 0);
        cyc(0, 1, 1, 1, 0, 0, 3'd4, 0, 32'd0, 32'd8, 0);
        chk("blt_stall_pc", pc, 32'h30);
        cyc(0, 1, 0, 1, 0, 0, 3'd4, 0, 32'd0, 32'd8, 0);
        chk("blt_pc", pc, 32'h38);

        // jalr beats jal, bit 0 cleared
        cyc(0, 1, 0, 0, 1, 1, 3'd0, 0, 32'h1235, 32'd64, 0);
        chk("jalr_pc", pc, 32'h1234);

        // Misaligned jal traps; later steps ignored; clear beats stall
        go_to(32'h10);
        cyc(0, 1, 0, 0, 1, 0, 3'd0, 0, 32'd0, 32'd6, 0);
        chk("trap_set", {31'd0, trap}, 32'd1);
        chk("trap_addr_val", trap_addr, 32'h16);
        chk("trap_pc_hold", pc, 32'h10);
        cyc(0, 1, 0, 0, 1, 0, 3'd0, 0, 32'd0, 32'd8, 0);
        chk("trap_ignore_pc", pc, 32'h10);
        cyc(0, 0, 1, 0, 0, 0, 3'd0, 0, 32'd0, 32'd0, 1);
        chk("trap_clear_pc", pc, 32'h100);
        chk("trap_addr_kept", trap_addr, 32'h16);

        // Wraparound, reset out of TRAP
        go_to(32'hFFFF_FFFC);
        cyc(0, 1, 0, 0, 0, 0, 3'd0, 0, 32'd0, 32'd0, 0);
        chk("wrap_pc", pc, 32'h0);
        go_to(32'h2);
        chk("trap_jalr", {31'd0, trap}, 32'd1);
        cyc(1, 1, 0, 0, 0, 0, 3'd0, 0, 32'd0, 32'd0, 1);
        chk("rst_trap_pc", pc, RV);
        chk("rst_trap_clr", {31'd0, trap}, 32'd0);

        // Three branches, two taken
        cyc(0, 1, 0, 1, 0, 0, 3'd0, 1, 32'd0, 32'd8, 0);
        cyc(0, 1, 0, 1, 0, 0, 3'd1, 1, 32'd0, 32'd8, 0);
        cyc(0, 1, 0, 1, 0, 0, 3'd6, 0, 32'd0, 32'd8, 0);
        chk("br3_pc", pc, 32'd20);
`ifdef PC_BRANCH_STATS_EN
        chk("stats_count", br_count, 32'd3);
        chk("stats_taken", br_taken_count, 32'd2);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rim;
            logic [31:0] ralu;
            rim  = ($urandom_range(0, 7) == 0) ? $urandom() : (($urandom() & 32'h0000_00FC) - 32'h80);
            ralu = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h0000_FFFC);
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ralu, rim, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
